alu_serial_engine: RTL and testbench

- Bit-serial, multi-cycle ALU engine over WIDTH-bit operands.
- Uses the same 4-bit opcode encoding as the single-bit slice datapath.
- Processes operands LSB-first, one bit per clock, and holds the carry in a flop between bits.
- Serves as the area-optimised execute unit for low-cost cores; a start/busy/done handshake connects it to the control sequencer.

---
 rtl/alu_serial_engine.sv | 153 +++++++++++++++
 tb/tb_alu_serial_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_serial_engine.sv
// Bit-serial ALU: processes WIDTH-bit operands LSB-first, one bit per clock, with a
// start/busy/done handshake. Result and flags are committed together in a single finish cycle.
module alu_serial_engine #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpNor   = 4'b0100;
  localparam logic [3:0] OpXor   = 4'b0101;
  localparam logic [3:0] OpXnor  = 4'b0110;
  localparam logic [3:0] OpNand  = 4'b0111;
  localparam logic [3:0] OpPassA = 4'b1000;
  localparam logic [3:0] OpPassB = 4'b1001;
  localparam logic [3:0] OpSlt   = 4'b1011;
  localparam logic [3:0] OpSltu  = 4'b1100;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, c_msb_q;
  logic             done_q, cout_q, zero_q, ovf_q;

  logic             start_inv, sub_op, arith_op, b_bit, sum_bit, carry_nxt, bit_sel, ovf_sub;
  logic             last_bit;
  logic [WIDTH-1:0] final_res;

  // Subtract-style ops invert B and inject a carry of 1.
  assign start_inv = (op == OpSub) || (op == OpSlt) || (op == OpSltu);
  assign sub_op    = (op_q == OpSub) || (op_q == OpSlt) || (op_q == OpSltu);
  assign arith_op  = sub_op || (op_q == OpAdd);
  assign b_bit     = b_q[0] ^ sub_op;
  assign sum_bit   = a_q[0] ^ b_bit ^ carry_q;
  assign carry_nxt = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
  assign ovf_sub   = c_msb_q ^ carry_q;
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    bit_sel = 1'b0;
    case (op_q)
      OpAdd, OpSub, OpSlt, OpSltu: bit_sel = sum_bit;
      OpAnd:   bit_sel = a_q[0] & b_q[0];
      OpOr:    bit_sel = a_q[0] | b_q[0];
      OpNor:   bit_sel = ~(a_q[0] | b_q[0]);
      OpXor:   bit_sel = a_q[0] ^ b_q[0];
      OpXnor:  bit_sel = ~(a_q[0] ^ b_q[0]);
      OpNand:  bit_sel = ~(a_q[0] & b_q[0]);
      OpPassA: bit_sel = a_q[0];
      OpPassB: bit_sel = b_q[0];
      default: bit_sel = 1'b0;
    endcase
  end

  always_comb begin
    final_res = acc_q;
    if (op_q == OpSlt) begin
      final_res    = '0;
      final_res[0] = acc_q[WIDTH-1] ^ ovf_sub;
    end else if (op_q == OpSltu) begin
      final_res    = '0;
      final_res[0] = ~carry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun:    if (last_bit) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            carry_q <= start_inv;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          acc_q   <= {bit_sel, acc_q[WIDTH-1:1]};
          carry_q <= carry_nxt;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 2)) c_msb_q <= carry_nxt;
        end
        StFinish: begin
          result_q <= final_res;
          zero_q   <= (final_res == '0);
          cout_q   <= arith_op & carry_q;
          ovf_q    <= ((op_q == OpAdd) || (op_q == OpSub)) & ovf_sub;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_engine.sv
// Self-checking bench for alu_serial_engine: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_serial_engine;

  localparam int unsigned W = 32;

  logic         clk, rst_n, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, cout, zero, overflow;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  alu_serial_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    case (mop)
      4'd0: begin
        s = {1'b0, ma} + {1'b0, mb};
        r = s[W-1:0]; c = s[W];
        v = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
      end
      4'd1: begin
        s = {1'b0, ma} + {1'b0, ~mb} + 1;
        r = s[W-1:0]; c = s[W];
        v = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
      end
      4'd2: r = ma & mb;
      4'd3: r = ma | mb;
      4'd4: r = ~(ma | mb);
      4'd5: r = ma ^ mb;
      4'd6: r = ~(ma ^ mb);
      4'd7: r = ~(ma & mb);
      4'd8: r = ma;
      4'd9: r = mb;
      4'd11: begin r = W'($signed(ma) < $signed(mb)); c = (ma >= mb); end
      4'd12: begin r = W'(ma < mb); c = (ma >= mb); end
      default: ;
    endcase
  endfunction

  // Launches one op, waits for done (bounded), checks latency, busy length and outputs.
  // If inject is set, a conflicting start is pulsed mid-run and must be ignored.
  task automatic run_op(input string tag, input logic [3:0] top, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input bit inject);
    logic [W-1:0] er;
    logic ec, ev;
    int n, busy_cnt;
    model(top, ta, tb, er, ec, ev);
    start = 1'b1; op = top; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; op = $urandom; a = $urandom; b = $urandom;
    busy_cnt = int'(busy);
    n = 0;
    while (n < W + 8) begin
      if (inject && n == 10) begin
        start = 1'b1; op = ~top; a = ~ta; b = ta;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) break;
      busy_cnt += int'(busy);
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(W + 1));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " cout"}, 64'(cout), 64'(ec));
    check({tag, " overflow"}, 64'(overflow), 64'(ev));
    check({tag, " zero"}, 64'(zero), 64'(er == '0));
  endtask

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    bit seen_done;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'({cout, zero, overflow}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op("sub_eq", 4'd1, 32'd5, 32'd5, 1'b0);
    run_op("slt", 4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sltu", 4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      run_op($sformatf("logic_op%0d", i), 4'(i), 32'hF0F0_A5A5, 32'h0FF0_5A5A, 1'b0);
    end
    check("and_const", 64'(32'hF0F0_A5A5 & 32'h0FF0_5A5A), 64'(32'h00F0_0000));

    run_op("mid_run_start", 4'd0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    // Back-to-back: the call starts while the previous done is still high.
    run_op("b2b_first", 4'd5, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0);
    run_op("b2b_second", 4'd1, 32'h0000_0010, 32'h0000_0020, 1'b0);

    // Reset mid-operation.
    run_op("pre_reset", 4'd0, 32'd1, 32'd1, 1'b0);
    start = 1'b1; op = 4'd0; a = 32'h0000_FFFF; b = 32'h0000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort result", 64'(result), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_n = 1'b1;
      if (done) seen_done = 1'b1;
    end
    check("abort no_done", 64'(seen_done), 64'd0);
    run_op("after_reset", 4'd0, 32'd3, 32'd4, 1'b0);
    check("after_reset value", 64'(result), 64'd7);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom; rb = $urandom;
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = 32'h8000_0000;
      if (i % 8 == 2) rb = 32'h7FFF_FFFF;
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
